// File: rtl/microwave_pkg.sv
// Shared state encodings and default timing constants for the microwave cook controller.
package microwave_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SET   = 3'd1,
      ST_COOK  = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam int CLK_HZ_DEF   = 100_000_000;
   localparam int ADD_SEC_DEF  = 30;
   localparam int MAX_SEC_DEF  = 5999;
   localparam int BEEP_SEC_DEF = 3;
   localparam int REM_W        = 13;

endpackage

// File: rtl/microwave_cook_fsm_if.sv
// Button/door inputs and status outputs of the microwave controller, bundled as one port.
interface microwave_cook_fsm_if
   import microwave_pkg::*;
   ;
   logic             btn_add;
   logic             btn_start;
   logic             btn_cancel;
   logic             door_open;
   logic [2:0]       state;
   logic [REM_W-1:0] remaining_sec;
   logic             heater_on;
   logic             beep;

   modport master (
      output btn_add, btn_start, btn_cancel, door_open,
      input  state, remaining_sec, heater_on, beep
   );

   modport slave (
      input  btn_add, btn_start, btn_cancel, door_open,
      output state, remaining_sec, heater_on, beep
   );
endinterface

// File: rtl/microwave_sec_tick.sv
// One-second tick generator: counts enabled cycles up to CLK_HZ-1, pulses tick_o on the last one.
module microwave_sec_tick #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Clear wins over enable so a fresh second always starts from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/microwave_cook_fsm.sv
// Microwave cook controller: time entry, countdown with pause/resume, and end-of-cook beep.
module microwave_cook_fsm
   import microwave_pkg::*;
#(
   parameter int CLK_HZ   = CLK_HZ_DEF,
   parameter int ADD_SEC  = ADD_SEC_DEF,
   parameter int MAX_SEC  = MAX_SEC_DEF,
   parameter int BEEP_SEC = BEEP_SEC_DEF
) (
   input  logic           clk,
   input  logic           reset_n,
   microwave_cook_fsm_if.slave bus
);

   localparam int            BW        = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;
   localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SEC - 1);
   localparam logic [13:0]   ADD14     = 14'(ADD_SEC);
   localparam logic [13:0]   MAX14     = 14'(MAX_SEC);

   function automatic logic [REM_W-1:0] sat_rem(input logic [13:0] sum);
      return (sum > MAX14) ? MAX14[REM_W-1:0] : sum[REM_W-1:0];
   endfunction

   state_e           state_q, state_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic [BW-1:0]    bcnt_q, bcnt_d;
   logic             heater_q, beep_q;
   logic             tick, tick_en, tick_clr;
   logic             do_cancel, do_start, do_add, any_btn;
   logic [13:0]      rem14;

   assign do_cancel = bus.btn_cancel;
   assign do_start  = bus.btn_start & ~bus.btn_cancel;
   assign do_add    = bus.btn_add & ~bus.btn_start & ~bus.btn_cancel;
   assign any_btn   = bus.btn_add | bus.btn_start | bus.btn_cancel;
   assign rem14     = {1'b0, rem_q};

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      bcnt_d  = bcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (do_start && !bus.door_open) begin
               state_d = ST_COOK;
               rem_d   = sat_rem(ADD14);
            end else if (do_add) begin
               state_d = ST_SET;
               rem_d   = sat_rem(ADD14);
            end
         end
         ST_SET, ST_PAUSE: begin
            if (do_cancel) begin
               state_d = ST_IDLE;
               rem_d   = '0;
            end else if (do_start && !bus.door_open) begin
               state_d = ST_COOK;
            end else if (do_add) begin
               rem_d = sat_rem(rem14 + ADD14);
            end
         end
         ST_COOK: begin
            // An open door freezes the count even if a tick lands on the same edge.
            if (do_cancel || bus.door_open) begin
               state_d = ST_PAUSE;
            end else if (do_add && tick) begin
               rem_d = sat_rem(rem14 + ADD14 - 14'd1);
            end else if (do_add) begin
               rem_d = sat_rem(rem14 + ADD14);
            end else if (tick) begin
               if (rem_q <= REM_W'(1)) begin
                  rem_d   = '0;
                  state_d = ST_DONE;
                  bcnt_d  = '0;
               end else begin
                  rem_d = rem_q - REM_W'(1);
               end
            end
         end
         ST_DONE: begin
            if (any_btn) begin
               state_d = ST_IDLE;
            end else if (tick) begin
               if (bcnt_q == BEEP_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  bcnt_d = bcnt_q + BW'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            rem_d   = '0;
         end
      endcase
   end

   // The second counter restarts on every entry into a timed state and holds while paused.
   assign tick_en  = (state_q == ST_COOK) || (state_q == ST_DONE);
   assign tick_clr = (state_d != state_q) && ((state_d == ST_COOK) || (state_d == ST_DONE));

   microwave_sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .clr_i   (tick_clr),
      .en_i    (tick_en),
      .tick_o  (tick)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         rem_q    <= '0;
         bcnt_q   <= '0;
         heater_q <= 1'b0;
         beep_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         bcnt_q   <= bcnt_d;
         heater_q <= (state_d == ST_COOK);
         beep_q   <= (state_d == ST_DONE);
      end
   end

   assign bus.state         = state_q;
   assign bus.remaining_sec = rem_q;
   assign bus.heater_on     = heater_q;
   assign bus.beep          = beep_q;

endmodule

// File: tb/tb_microwave_cook_fsm.sv
// Scoreboard bench for microwave_cook_fsm: directed scenarios plus random button/door traffic.
module tb_microwave_cook_fsm;
   import microwave_pkg::*;

   localparam int CLK_HZ = 10;
   localparam int ADD    = ADD_SEC_DEF;
   localparam int MAX    = MAX_SEC_DEF;
   localparam int BEEP   = BEEP_SEC_DEF;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   microwave_cook_fsm_if bus();

   microwave_cook_fsm #(
      .CLK_HZ   (CLK_HZ),
      .ADD_SEC  (ADD),
      .MAX_SEC  (MAX),
      .BEEP_SEC (BEEP)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int st;
      int rem;
      int heat;
      int bp;
   } exp_t;

   exp_t   expq[$];
   int     checks = 0;
   int     errors = 0;
   state_e m_st;
   int     m_rem, m_cyc, m_beeps;
   bit     door;
   bit     rst_hold;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour: seconds as plain integers, elapsed cycles counted since entry.
   task automatic model_step(input bit a, input bit s, input bit c, input bit d, input bit rl);
      state_e nx;
      bit     tick;
      int     r;
      exp_t   e;
      if (rl) begin
         m_st = ST_IDLE; m_rem = 0; m_cyc = 0; m_beeps = 0;
      end else begin
         tick = 1'b0;
         if (m_st == ST_COOK || m_st == ST_DONE) begin
            tick  = ((m_cyc % CLK_HZ) == CLK_HZ - 1);
            m_cyc = m_cyc + 1;
         end
         nx = m_st;
         case (m_st)
            ST_IDLE: begin
               if (c) begin
               end else if (s) begin
                  if (!d) begin nx = ST_COOK; m_rem = (ADD > MAX) ? MAX : ADD; end
               end else if (a) begin
                  nx = ST_SET; m_rem = (ADD > MAX) ? MAX : ADD;
               end
            end
            ST_SET, ST_PAUSE: begin
               if (c) begin
                  nx = ST_IDLE; m_rem = 0;
               end else if (s) begin
                  if (!d) nx = ST_COOK;
               end else if (a) begin
                  m_rem = (m_rem + ADD > MAX) ? MAX : m_rem + ADD;
               end
            end
            ST_COOK: begin
               if (c || d) begin
                  nx = ST_PAUSE;
               end else begin
                  r = m_rem;
                  if (a && !s) r = r + ADD;
                  if (tick) r = r - 1;
                  if (r > MAX) r = MAX;
                  if (tick && r <= 0) begin r = 0; nx = ST_DONE; end
                  m_rem = r;
               end
            end
            ST_DONE: begin
               if (a || s || c) begin
                  nx = ST_IDLE;
               end else if (tick) begin
                  m_beeps = m_beeps + 1;
                  if (m_beeps >= BEEP) nx = ST_IDLE;
               end
            end
            default: nx = ST_IDLE;
         endcase
         if (nx != m_st && (nx == ST_COOK || nx == ST_DONE)) begin
            m_cyc = 0; m_beeps = 0;
         end
         m_st = nx;
      end
      e.st   = int'(m_st);
      e.rem  = m_rem;
      e.heat = (m_st == ST_COOK) ? 1 : 0;
      e.bp   = (m_st == ST_DONE) ? 1 : 0;
      expq.push_back(e);
   endtask

   task automatic cycle(input bit a, input bit s, input bit c);
      @(negedge clk);
      reset_n        = !rst_hold;
      bus.btn_add    = a;
      bus.btn_start  = s;
      bus.btn_cancel = c;
      bus.door_open  = door;
      model_step(a, s, c, door, rst_hold);
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   task automatic async_reset_check();
      @(negedge clk);
      chk("pre_reset_heater", int'(bus.heater_on), 1);
      rst_hold       = 1'b1;
      reset_n        = 1'b0;
      bus.btn_add    = 1'b0;
      bus.btn_start  = 1'b0;
      bus.btn_cancel = 1'b0;
      #1;
      chk("async_state", int'(bus.state), int'(ST_IDLE));
      chk("async_rem", int'(bus.remaining_sec), 0);
      chk("async_heater", int'(bus.heater_on), 0);
      chk("async_beep", int'(bus.beep), 0);
      model_step(1'b0, 1'b0, 1'b0, door, 1'b1);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("state", int'(bus.state), e.st);
            chk("remaining_sec", int'(bus.remaining_sec), e.rem);
            chk("heater_on", int'(bus.heater_on), e.heat);
            chk("beep", int'(bus.beep), e.bp);
         end
      end
   end

   initial begin : driver
      bit a, s, c;
      door = 1'b0; rst_hold = 1'b1;
      bus.btn_add = 1'b0; bus.btn_start = 1'b0; bus.btn_cancel = 1'b0; bus.door_open = 1'b0;
      m_st = ST_IDLE; m_rem = 0; m_cyc = 0; m_beeps = 0;
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      chk("reset_state", int'(bus.state), int'(ST_IDLE));
      chk("reset_rem", int'(bus.remaining_sec), 0);
      rst_hold = 1'b0;
      cycle(1'b0, 1'b0, 1'b0);

      // Two adds then start: full 60 s cook, first decrement after CLK_HZ cycles, then beep.
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      settle();
      chk("cook60_state", int'(bus.state), int'(ST_COOK));
      chk("cook60_rem", int'(bus.remaining_sec), 60);
      chk("cook60_heater", int'(bus.heater_on), 1);
      repeat (9) cycle(1'b0, 1'b0, 1'b0);
      settle();
      chk("before_first_tick", int'(bus.remaining_sec), 60);
      cycle(1'b0, 1'b0, 1'b0);
      settle();
      chk("first_tick", int'(bus.remaining_sec), 59);
      repeat (590) cycle(1'b0, 1'b0, 1'b0);
      settle();
      chk("done_state", int'(bus.state), int'(ST_DONE));
      chk("done_beep", int'(bus.beep), 1);
      chk("done_rem", int'(bus.remaining_sec), 0);
      repeat (29) cycle(1'b0, 1'b0, 1'b0);
      settle();
      chk("beep_last", int'(bus.beep), 1);
      cycle(1'b0, 1'b0, 1'b0);
      settle();
      chk("beep_end_state", int'(bus.state), int'(ST_IDLE));
      chk("beep_end_beep", int'(bus.beep), 0);

      // Quick start, door opens at 17 s, resume after closing.
      cycle(1'b0, 1'b1, 1'b0);
      settle();
      chk("quick_rem", int'(bus.remaining_sec), 30);
      repeat (130) cycle(1'b0, 1'b0, 1'b0);
      settle();
      chk("at17_rem", int'(bus.remaining_sec), 17);
      door = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);
      settle();
      chk("door_pause_state", int'(bus.state), int'(ST_PAUSE));
      chk("door_pause_heater", int'(bus.heater_on), 0);
      repeat (20) cycle(1'b0, 1'b1, 1'b0);
      settle();
      chk("door_hold_rem", int'(bus.remaining_sec), 17);
      door = 1'b0;
      cycle(1'b0, 1'b1, 1'b0);
      repeat (10) cycle(1'b0, 1'b0, 1'b0);
      settle();
      chk("resume_rem", int'(bus.remaining_sec), 16);
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1);
      settle();
      chk("cancel_idle_rem", int'(bus.remaining_sec), 0);

      // Saturation at the ceiling.
      repeat (200) cycle(1'b1, 1'b0, 1'b0);
      settle();
      chk("sat_rem", int'(bus.remaining_sec), MAX);

      // Simultaneous pulses in SET(30): cancel wins.
      cycle(1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1);
      settle();
      chk("prio_state", int'(bus.state), int'(ST_IDLE));
      chk("prio_rem", int'(bus.remaining_sec), 0);

      // Add coincident with the final tick keeps cooking.
      cycle(1'b0, 1'b1, 1'b0);
      repeat (299) cycle(1'b0, 1'b0, 1'b0);
      settle();
      chk("at1_rem", int'(bus.remaining_sec), 1);
      cycle(1'b1, 1'b0, 1'b0);
      settle();
      chk("tick_add_rem", int'(bus.remaining_sec), ADD - 1 + 1);
      chk("tick_add_state", int'(bus.state), int'(ST_COOK));

      // Asynchronous reset mid-cook; pulses during reset are not remembered.
      repeat (5) cycle(1'b0, 1'b0, 1'b0);
      async_reset_check();
      cycle(1'b0, 1'b1, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      rst_hold = 1'b0;
      cycle(1'b0, 1'b0, 1'b0);
      settle();
      chk("post_reset_state", int'(bus.state), int'(ST_IDLE));
      chk("post_reset_rem", int'(bus.remaining_sec), 0);

      // Random traffic against the reference model.
      for (int i = 0; i < 6000; i++) begin
         a = ($urandom_range(0, 399) == 0);
         s = ($urandom_range(0, 59) == 0);
         c = ($urandom_range(0, 249) == 0);
         if ($urandom_range(0, 299) == 0) door = ~door;
         rst_hold = ($urandom_range(0, 1999) == 0);
         if ($urandom_range(0, 799) == 0) begin
            a = 1'b1; s = 1'b1; c = $urandom_range(0, 1) == 1;
         end
         cycle(a, s, c);
      end
      rst_hold = 1'b0;
      repeat (3) cycle(1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #2;
      chk("queue_drained", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/microwave_cook_fsm.md
MICROWAVE_COOK_FSM -- requirements
Module: microwave_cook_fsm

Interface
REQ-001 Parameter CLK_HZ, default 100000000, clock cycles per 1-second tick.
REQ-002 Parameter ADD_SEC, default 30, seconds added per add pulse.
REQ-003 Parameter MAX_SEC, default 5999, saturation ceiling for remaining time (99:59).
REQ-004 Parameter BEEP_SEC, default 3, seconds beep stays high in DONE.
REQ-005 clk  input  1  system clock, 100 MHz.
REQ-006 reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 btn_add  input  1  debounced single-cycle pulse, add ADD_SEC.
REQ-008 btn_start  input  1  debounced single-cycle pulse, start/resume.
REQ-009 btn_cancel  input  1  debounced single-cycle pulse, pause/clear.
REQ-010 door_open  input  1  level, 1 = door open; synchronised upstream.
REQ-011 state  output  3  current state encoding.
REQ-012 remaining_sec  output  13  remaining cook time, binary seconds.
REQ-013 heater_on  output  1  magnetron enable, high only in COOK.
REQ-014 beep  output  1  buzzer enable, high only in DONE.

Function
REQ-015 States IDLE, SET, COOK, PAUSE, DONE; all outputs registered, no combinational input-to-output path.
REQ-016 Simultaneous pulses resolved cancel > start > add; only the highest-priority pulse acts in a cycle.
REQ-017 IDLE: add -> SET, remaining_sec = ADD_SEC; start with door closed -> COOK, remaining_sec = ADD_SEC (quick start); cancel ignored.
REQ-018 SET: add -> remaining_sec = min(remaining_sec + ADD_SEC, MAX_SEC); start with door closed -> COOK; cancel -> IDLE, remaining_sec = 0.
REQ-019 COOK: 1-second tick counter cleared on every entry into COOK; each tick decrements remaining_sec by 1.
REQ-020 COOK: tick with remaining_sec == 1 -> remaining_sec = 0 and DONE on the same edge; remaining_sec never wraps below 0.
REQ-021 COOK: add saturates as in REQ-018 without interrupting cooking; add coincident with tick applies both (net +ADD_SEC-1, saturated).
REQ-022 COOK: cancel or door_open = 1 -> PAUSE on next edge, remaining_sec frozen; door_open overrides a coincident tick.
REQ-023 PAUSE: start with door closed -> COOK; start with door open ignored; cancel -> IDLE, remaining_sec = 0; add saturates as REQ-018.
REQ-024 DONE: beep = 1 for BEEP_SEC ticks, then IDLE; any button pulse -> IDLE immediately, beep = 0.
REQ-025 Add arithmetic in 14 bits before saturation compare; MAX_SEC < 8192.
REQ-026 First decrement occurs exactly CLK_HZ cycles after entering COOK.

Reset
REQ-027 reset_n low: state = IDLE, remaining_sec = 0, heater_on = 0, beep = 0, tick counter = 0, asynchronously.
REQ-028 Reset asserted mid-COOK drops heater_on immediately; release resumes in IDLE with no pending pulse honoured.

Structure
REQ-029 State encodings and ADD_SEC/MAX_SEC/BEEP_SEC defaults live in shared package microwave_pkg.
REQ-030 One sub-module microwave_sec_tick: counter to CLK_HZ-1 with clear and enable inputs, single-cycle tick output.
REQ-031 microwave_sec_tick enabled in COOK and DONE, held (not cleared) in PAUSE, cleared on entry to COOK and DONE.

Verification (CLK_HZ = 10 for simulation)
REQ-032 add x2, start, door closed -> COOK, remaining_sec 60, first decrement 10 cycles later, DONE after 600 cycles, beep high 30 cycles, then IDLE.
REQ-033 start in IDLE -> COOK with remaining_sec 30; door_open at remaining 17 -> PAUSE, heater_on 0, value held 17; door close + start -> COOK, decrement resumes.
REQ-034 200 add pulses -> remaining_sec saturates at 5999, never exceeds.
REQ-035 start + cancel + add same cycle in SET(30) -> IDLE, remaining_sec 0.
REQ-036 COOK at remaining 1, tick and add same cycle -> remaining_sec 30, stays COOK.
REQ-037 reset_n low mid-COOK -> outputs zero without clock edge; after release, IDLE, remaining_sec 0.
